// File: rtl/jpeg_bit_packer_if.sv
// Purpose : bundles the packer's code-input, stuffer-side and flush handshake signals.
// Ports   : code side  - ena_in, rdy_out, code, code_len, flush_in
//           word side  - out, ena_out, rdy_in; flush side - flush_out, done_in, done_out
//           word_count exists only when JPEG_BIT_PACKER_STATS_EN is defined.
// modport slave is the packer; modport master is whoever drives codes and plays the stuffer.
interface jpeg_bit_packer_if #(
   parameter int CODE_W = 32
);
   localparam int LEN_W = $clog2(CODE_W + 1);

   logic              ena_in;
   logic              rdy_out;
   logic [CODE_W-1:0] code;
   logic [LEN_W-1:0]  code_len;
   logic              flush_in;
   logic [15:0]       out;
   logic              ena_out;
   logic              rdy_in;
   logic              flush_out;
   logic              done_in;
   logic              done_out;
`ifdef JPEG_BIT_PACKER_STATS_EN
   logic [31:0]       word_count;
`endif

   modport slave (
`ifdef JPEG_BIT_PACKER_STATS_EN
      output word_count,
`endif
      input  ena_in, code, code_len, flush_in, rdy_in, done_in,
      output rdy_out, out, ena_out, flush_out, done_out
   );

   modport master (
`ifdef JPEG_BIT_PACKER_STATS_EN
      input  word_count,
`endif
      output ena_in, code, code_len, flush_in, rdy_in, done_in,
      input  rdy_out, out, ena_out, flush_out, done_out
   );
endinterface

// File: rtl/jpeg_bit_packer.sv
// Purpose : packs right-justified variable-length codes MSB-first into 16-bit words,
//           pads the last partial word with 1s at end of scan and sequences the stuffer flush.
// Latency : a code that brings fill to 16+ raises ena_out on the next cycle.
// Backpr. : out/ena_out hold while rdy_in is low; rdy_out drops when a full word is stuck.
// Ports   : clk, rst_n (async, active-low), bus (jpeg_bit_packer_if.slave).
// Option  : JPEG_BIT_PACKER_STATS_EN adds bus.word_count, a saturating count of emitted words.
module jpeg_bit_packer #(
   parameter int CODE_W = 32
) (
   input logic               clk,
   input logic               rst_n,
   jpeg_bit_packer_if.slave  bus
);

   localparam int LEN_W  = $clog2(CODE_W + 1);
   localparam int ACC_W  = CODE_W + 15;
   localparam int FILL_W = $clog2(CODE_W + 16);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [FILL_W-1:0] SIXTEEN = FILL_W'(16);

   // acc is left-justified: bit ACC_W-1 is the oldest unsent bit. Bits at and
   // below position fill (counted from the MSB) are always zero, so new codes
   // and padding can simply be OR-ed in.
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_nxt;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_nxt;
   logic [FILL_W-1:0] fill_ae;
   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              emit;
   logic              accept;
   logic [CODE_W-1:0] code_mask;
   logic [CODE_W-1:0] code_m;
   logic [ACC_W-1:0]  code_lj;

   assign bus.ena_out   = (fill >= SIXTEEN);
   assign emit          = bus.ena_out && bus.rdy_in;
   // fill as seen after this cycle's emit; a new code lands right behind it
   assign fill_ae       = emit ? (fill - SIXTEEN) : fill;
   assign bus.rdy_out   = (state == ST_RUN) && (fill_ae < SIXTEEN);
   assign accept        = bus.ena_in && bus.rdy_out;
   assign bus.out       = acc[ACC_W-1 -: 16];
   assign bus.flush_out = (state == ST_FLUSH);
   assign bus.done_out  = (state == ST_DONE);

   // Shifting by code_len == CODE_W yields zero, so the mask becomes all ones.
   assign code_mask = ~({CODE_W{1'b1}} << bus.code_len);
   assign code_m    = bus.code & code_mask;
   // Left-justify the code so its first bit sits at the accumulator MSB;
   // it is then moved down by fill_ae to sit behind the buffered bits.
   assign code_lj   = {code_m, 15'b0} << (LEN_W'(CODE_W) - bus.code_len);

   always_comb begin
      acc_nxt   = acc;
      fill_nxt  = fill;
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (bus.flush_in && (fill < SIXTEEN)) begin
               if (fill != '0) begin
                  // pad the partial word with 1s and hand it to DRAIN as a full word
                  acc_nxt   = acc | {16'hFFFF >> fill, {(ACC_W-16){1'b0}}};
                  fill_nxt  = SIXTEEN;
                  state_nxt = ST_DRAIN;
               end else begin
                  state_nxt = ST_FLUSH;
               end
            end else begin
               acc_nxt  = emit ? (acc << 16) : acc;
               fill_nxt = fill_ae;
               if (accept) begin
                  acc_nxt  = acc_nxt | (code_lj >> fill_ae);
                  fill_nxt = fill_ae + FILL_W'(bus.code_len);
               end
            end
         end
         ST_DRAIN: begin
            if (emit) begin
               acc_nxt   = acc << 16;
               fill_nxt  = fill_ae;
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (bus.done_in) begin
               state_nxt = ST_DONE;
            end
         end
         default: begin
            // ST_DONE is terminal until reset
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         fill  <= '0;
         state <= ST_RUN;
      end else begin
         acc   <= acc_nxt;
         fill  <= fill_nxt;
         state <= state_nxt;
      end
   end

`ifdef JPEG_BIT_PACKER_STATS_EN
   logic [31:0] word_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_count_q <= '0;
      end else if (emit && (word_count_q != 32'hFFFF_FFFF)) begin
         word_count_q <= word_count_q + 32'd1;
      end
   end

   assign bus.word_count = word_count_q;
`endif

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Purpose : self-checking bench for jpeg_bit_packer (hand sequences, vector table, word scoreboard).
// Latency : n/a (bench).
// Backpr. : drives rdy_in low for stall sequences; the scoreboard pops only on real transfers.
module tb_jpeg_bit_packer;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   jpeg_bit_packer_if #(.CODE_W(32)) bus ();

   jpeg_bit_packer #(.CODE_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] code;
      logic [5:0]  len;
      logic        exp_ena;   // ena_out one cycle after the code is accepted
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   int          tb_emits = 0;
   int          emits_base = 0;
   logic [15:0] exp_q[$];
   bit          mbits[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a plain bit queue, cut into 16-bit words as they fill.
   function automatic void model_push(input logic [31:0] c, input int l);
      for (int i = l - 1; i >= 0; i--) mbits.push_back(c[i]);
      while (mbits.size() >= 16) begin
         logic [15:0] w;
         for (int j = 15; j >= 0; j--) w[j] = mbits.pop_front();
         exp_q.push_back(w);
      end
   endfunction

   function automatic void model_flush();
      if (mbits.size() > 0) begin
         while (mbits.size() < 16) mbits.push_back(1'b1);
         model_push(32'h0, 0);
      end
   endfunction

   // Word monitor: a word transfers at the next posedge when ena_out && rdy_in.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.ena_out === 1'b1 && bus.rdy_in === 1'b1) begin
         tb_emits++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_extra: got word %h, expected none", bus.out);
         end else begin
            chk("sb_word", {16'h0, bus.out}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.ena_in === 1'b1)
         assert (bus.code_len <= 6'd32) else $error("code_len out of range: %0d", bus.code_len);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one code, wait (bounded) for rdy_out, return #1 after the accepting edge.
   task automatic send(input logic [31:0] c, input logic [5:0] l);
      int n;
      n = 0;
      bus.ena_in   = 1'b1;
      bus.code     = c;
      bus.code_len = l;
      @(negedge clk);
      while (bus.rdy_out !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.rdy_out !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: rdy_out %b after %0d cycles, required 1", bus.rdy_out, n);
      end else begin
         model_push(c, int'(l));
      end
      @(posedge clk);
      #1;
      bus.ena_in = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ena_out"},   {31'h0, bus.ena_out},   32'h0);
      chk({tag, "_flush_out"}, {31'h0, bus.flush_out}, 32'h0);
      chk({tag, "_done_out"},  {31'h0, bus.done_out},  32'h0);
      chk({tag, "_rdy_out"},   {31'h0, bus.rdy_out},   32'h1);
      chk({tag, "_out"},       {16'h0, bus.out},       32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      vecs[0] = '{32'h0000_0003,  6'd2,  1'b0};
      vecs[1] = '{32'h0000_ABCD,  6'd16, 1'b1};
      vecs[2] = '{32'h0000_0000,  6'd0,  1'b0};
      vecs[3] = '{32'hFFFF_FFFF,  6'd7,  1'b0};
      vecs[4] = '{32'h1234_5678,  6'd32, 1'b1};
      vecs[5] = '{32'h0000_0001,  6'd1,  1'b0};
      vecs[6] = '{32'h0000_003F,  6'd6,  1'b1};
      vecs[7] = '{32'h0000_0005,  6'd3,  1'b0};

      bus.ena_in   = 1'b0;
      bus.code     = '0;
      bus.code_len = '0;
      bus.flush_in = 1'b0;
      bus.rdy_in   = 1'b1;
      bus.done_in  = 1'b0;
      rst_n        = 1'b0;

      // ---- reset ----
      #12;
      rst_n = 1'b1;
      tick();
      chk_reset_outputs("reset");

      // ---- four small codes make one word ----
      for (int k = 0; k < 4; k++) send(32'hA, 6'd4);
      chk("small_ena_after_4th", {31'h0, bus.ena_out}, 32'h1);
      chk("small_out", {16'h0, bus.out}, 32'hAAAA);
      tick();
      chk("small_fill_zero", {31'h0, bus.ena_out}, 32'h0);

      // ---- straddling 32-bit code ----
      send(32'h7FFF, 6'd15);
      send(32'hDEAD_BEEF, 6'd32);
      chk("strad_ena1", {31'h0, bus.ena_out}, 32'h1);
      chk("strad_out1", {16'h0, bus.out}, 32'hFFFF);
      chk("strad_rdy1", {31'h0, bus.rdy_out}, 32'h0);
      tick();
      chk("strad_ena2", {31'h0, bus.ena_out}, 32'h1);
      chk("strad_out2", {16'h0, bus.out}, 32'hBD5B);
      chk("strad_rdy2", {31'h0, bus.rdy_out}, 32'h1);
      tick();
      chk("strad_ena_after", {31'h0, bus.ena_out}, 32'h0);
      send(32'h1, 6'd1);
      tick();

      // ---- backpressure: word held, pending code waits ----
      bus.rdy_in = 1'b0;
      send(32'h1234, 6'd16);
      bus.ena_in   = 1'b1;
      bus.code     = 32'h5;
      bus.code_len = 6'd4;
      for (int k = 0; k < 5; k++) begin
         chk("bp_out_stable", {16'h0, bus.out}, 32'h1234);
         chk("bp_ena_held", {31'h0, bus.ena_out}, 32'h1);
         chk("bp_rdy_low", {31'h0, bus.rdy_out}, 32'h0);
         tick();
      end
      bus.rdy_in = 1'b1;
      @(negedge clk);
      chk("bp_accept_on_release", {31'h0, bus.rdy_out}, 32'h1);
      model_push(32'h5, 4);
      tick();
      bus.ena_in = 1'b0;
      chk("bp_released", {31'h0, bus.ena_out}, 32'h0);
      send(32'hFFF, 6'd12);
      tick();

      // ---- flush with padding ----
      send(32'h16, 6'd5);
      bus.flush_in = 1'b1;
      model_flush();
      tick();
      chk("pad_ena", {31'h0, bus.ena_out}, 32'h1);
      chk("pad_out", {16'h0, bus.out}, 32'hB7FF);
      chk("pad_rdy", {31'h0, bus.rdy_out}, 32'h0);
      chk("pad_flush_out", {31'h0, bus.flush_out}, 32'h0);
      tick();
      chk("flush_rise", {31'h0, bus.flush_out}, 32'h1);
      chk("flush_ena_low", {31'h0, bus.ena_out}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("flush_hold", {31'h0, bus.flush_out}, 32'h1);
         chk("flush_not_done", {31'h0, bus.done_out}, 32'h0);
      end
      bus.done_in = 1'b1;
      tick();
      chk("done_rise", {31'h0, bus.done_out}, 32'h1);
      chk("done_flush_low", {31'h0, bus.flush_out}, 32'h0);
      chk("done_rdy_low", {31'h0, bus.rdy_out}, 32'h0);
      bus.done_in  = 1'b0;
      bus.flush_in = 1'b0;
`ifdef JPEG_BIT_PACKER_STATS_EN
      chk("word_count_scan1", bus.word_count, 32'(tb_emits - emits_base));
`endif

      // ---- reset mid-drain ----
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      mbits.delete();
      exp_q.delete();
      tick();
      send(32'h5, 6'd3);
      bus.rdy_in   = 1'b0;
      bus.flush_in = 1'b1;
      tick();
      chk("mid_pad_out", {16'h0, bus.out}, 32'hBFFF);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      bus.flush_in = 1'b0;
      bus.rdy_in   = 1'b1;
      mbits.delete();
      exp_q.delete();
      #3;
      emits_base = tb_emits;
      rst_n = 1'b1;
      tick();
`ifdef JPEG_BIT_PACKER_STATS_EN
      chk("word_count_reset", bus.word_count, 32'h0);
`endif

      // ---- vector table: second scan from fill = 0 ----
      for (int v = 0; v < 8; v++) begin
         send(vecs[v].code, vecs[v].len);
         chk($sformatf("vec%0d_ena", v), {31'h0, bus.ena_out}, {31'h0, vecs[v].exp_ena});
      end
      bus.flush_in = 1'b1;
      model_flush();
      tick();
      tick();
      chk("scan2_flush_out", {31'h0, bus.flush_out}, 32'h1);
      bus.done_in = 1'b1;
      tick();
      chk("scan2_done_out", {31'h0, bus.done_out}, 32'h1);
      bus.done_in  = 1'b0;
      bus.flush_in = 1'b0;
      tick();
      chk("sb_empty", exp_q.size(), 32'h0);
`ifdef JPEG_BIT_PACKER_STATS_EN
      chk("word_count_scan2", bus.word_count, 32'(tb_emits - emits_base));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jpeg_bit_packer.md
# jpeg_bit_packer

- Packs variable-length entropy-coded bit strings (Huffman code plus appended amplitude bits) MSB-first into 16-bit words.
- Sits directly upstream of the byte stuffer: feeds it `out`/`ena_out`, takes its `rdy_out` as backpressure, and sequences its end-of-scan flush.
- At end of scan, pads the final partial word with 1 bits and drains it, then holds the stuffer's flush until the stuffer reports done.

## Interface
- `CODE_W`, default 32: maximum code length in bits; `code_len` is `$clog2(CODE_W+1)` bits wide.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ena_in`  in  1: a code is presented; transfers when `ena_in && rdy_out`.
- `rdy_out`  out  1: packer can accept a code this cycle.
- `code`  in  CODE_W: right-justified bit string; bits at or above `code_len` are ignored (masked).
- `code_len`  in  `$clog2(CODE_W+1)`: valid bits, 0..CODE_W; 0 is a legal no-op.
- `flush_in`  in  1: end of scan, level, held until `done_out`; `ena_in` is low while it is high.
- `out`  out  16: next packed word, MSB = earliest bit.
- `ena_out`  out  1: `out` valid; drives the stuffer `ena_in`.
- `rdy_in`  in  1: from the stuffer `rdy_out`; a word transfers when `ena_out && rdy_in`.
- `flush_out`  out  1: to the stuffer `flush`.
- `done_in`  in  1: from the stuffer `done`.
- `done_out`  out  1: scan fully emitted; sticky until reset.

## Operation
- **Accumulator:** `acc` is CODE_W+15 bits, left-justified; `fill` counts valid bits, range 0..CODE_W+15.
- **Emit:** `emit = ena_out && rdy_in`, with `ena_out = (fill >= 16)` and no dependence on `rdy_in`. On emit, shift `acc` left 16 and decrement `fill` by 16.
- **Accept:** `fill_ae = fill - (emit ? 16 : 0)`. `rdy_out = (state == RUN) && (fill_ae < 16)`.
  - On accept, place the masked code at bit offset `fill_ae` from the MSB and set `fill <= fill_ae + code_len`. This never exceeds CODE_W+15.
  - Accept and emit in the same cycle are both honoured.
- **`out` source:** `out = acc[top:top-15]`, registered state only.
- **FSM, `RUN`:** normal operation.
  - `flush_in && fill < 16`: if `fill % 16 != 0`, OR 1s into bit positions `fill`..15, set `fill = 16`, go to `DRAIN`; otherwise go to `FLUSH`.
  - While `fill >= 16` during flush, stay in `RUN` and emit normally.
- **`DRAIN`:** emit the padded word; on emit, go to `FLUSH`.
- **`FLUSH`:** `flush_out = 1`; on `done_in`, go to `DONE`.
- **`DONE`:** `done_out = 1`, `flush_out = 0`, `rdy_out = 0`; stay until reset.
- `code_len > CODE_W` is illegal; the bench assertion fires and behaviour is undefined.

## Timing
- **Reset values:** `acc = 0`, `fill = 0`, `state = RUN`. `out = 16'h0000`, `ena_out = 0`, `flush_out = 0`, `done_out = 0`, `rdy_out = 1`.
- **Latency:** a code that raises `fill` to 16 or more in cycle N gives `ena_out = 1` in cycle N+1.
- **Backpressure:** while `ena_out && !rdy_in`, `out` and `ena_out` are held stable. `rdy_out` drops whenever `fill >= 16` without emit.
- **Throughput:** sustained at most one word per cycle; a 32-bit code at `fill = 15` drains in 2 cycles.
- **Flush sequence:** pad is applied the cycle after `flush_in` is seen with `fill < 16`. `flush_out` rises the cycle after the last emit. `done_out` rises the cycle after `done_in`.
- **Reset mid-operation:** async assertion clears all state immediately; `flush_out` and `done_out` drop combinationally-to-reset.

## Configuration
- Macro `JPEG_BIT_PACKER_STATS_EN`.
- **Defined:** adds output `word_count` (32 bits), reset 0, incremented on every emit and saturating at `32'hFFFF_FFFF`; counts padded words too.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset:** release `rst_n` with `rdy_in = 1` → `ena_out = 0`, `flush_out = 0`, `done_out = 0`, `rdy_out = 1`, `out = 16'h0000`.
- **Small codes:** four codes `4'b1010`, `code_len = 4`, on consecutive cycles → one word `16'hAAAA`, `ena_out` high the cycle after the 4th accept; `fill` returns to 0.
- **Straddling code:** `15'h7FFF` (len 15) then `32'hDEADBEEF` (len 32) → words `16'hFFFF`, `16'hBD5B` on consecutive cycles, `fill = 15`. `rdy_out` stays high after the first emit cycle.
- **Backpressure:** a word is pending, `rdy_in = 0` for 5 cycles → `out` stable, `ena_out` held, `rdy_out = 0`, no code lost. Release → word transfers in 1 cycle.
- **Flush with padding:** 5 bits `5'b10110` pending, assert `flush_in` → word `16'hB7FF` emitted, then `flush_out = 1` until `done_in`, `done_out = 1` one cycle later. With the macro defined, `word_count` increments by 1.
- **Reset mid-drain:** assert `rst_n = 0` during `DRAIN` while `rdy_in = 0` → all outputs return to reset values without a clock edge. The next scan packs correctly from `fill = 0`.
